// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM states, frame header bytes and frame length (FRAME_CHECKSUM_EN adds a checksum byte)
package freq_meter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_WAIT, S_GAP} state_e;
  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;
  function automatic int frame_len(input int num_words);
`ifdef FRAME_CHECKSUM_EN
    return 4 * num_words + 3;
`else
    return 4 * num_words + 2;
`endif
  endfunction
endpackage

// File: rtl/tx_watchdog.sv
// tx_watchdog: clearable cycle counter that pulses tc_o while counting into its terminal value
module tx_watchdog #(
  parameter int TERM = 65534
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(TERM) + 1;
  logic [W-1:0] cnt_q;
  // count enabled cycles since the last clear
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign tc_o = en_i && (cnt_q == W'(TERM - 1));
endmodule

// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: snapshots measurement words and streams a 0x55 0xAA headed frame byte by byte to an SPI transmitter (FRAME_CHECKSUM_EN appends a payload checksum)
module spi_frame_scheduler
  import freq_meter_pkg::*;
#(
  parameter int NUM_WORDS      = 5,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [32*NUM_WORDS-1:0]  data_in,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [15:0]              frame_cnt
);
  localparam int DW   = 32 * NUM_WORDS;
  localparam int FLEN = frame_len(NUM_WORDS);
  localparam int PEND = 2 + 4 * NUM_WORDS;
  localparam int IW   = $clog2(FLEN);
  localparam int GW   = $clog2(GAP_CYCLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(FLEN - 1);

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic [DW-1:0]  shadow_q;
  logic [GW-1:0]  gap_q;
  logic [7:0]     tx_data_q;
  logic [7:0]     csum;
  logic [15:0]    frame_cnt_q;
  logic           tx_start_q, busy_q, frame_done_q, frame_err_q, wd_tc;

  function automatic logic [7:0] frame_byte(input logic [IW-1:0] idx, input logic [DW-1:0] sh,
                                            input logic [7:0] cs);
    logic [DW-1:0] s;
    s = sh << {idx - IW'(2), 3'b000};
    return (idx == '0) ? HDR0 : (idx == IW'(1)) ? HDR1 : (int'(idx) < PEND) ? s[DW-1 -: 8] : cs;
  endfunction

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_q;
  // add each payload byte as it is launched so the trailing byte carries the total
  always_ff @(posedge sys_clk)
    if (rst || state_q == S_LATCH) csum_q <= '0;
    else if (state_q == S_SEND && idx_q >= IW'(2) && int'(idx_q) < PEND) csum_q <= csum_q + tx_data_q;
  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

  tx_watchdog #(.TERM(TIMEOUT_CYCLES - 1)) u_wd (
    .clk  (sys_clk),
    .rst  (rst),
    .clr_i(state_q == S_SEND),
    .en_i (state_q == S_WAIT),
    .tc_o (wd_tc)
  );

  // frame sequencer; every output is set on the transition into the state it belongs to
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      gap_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (enable) begin
          state_q <= S_LATCH;
          busy_q  <= 1'b1;
        end
        S_LATCH: begin
          shadow_q   <= data_in;
          idx_q      <= '0;
          tx_data_q  <= HDR0;
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: state_q <= S_WAIT;
        S_WAIT: if (tx_done) begin
          if (idx_q == LAST) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 1'b1;
            gap_q        <= GW'(GAP_CYCLES - 1);
            state_q      <= S_GAP;
          end else begin
            idx_q      <= idx_q + IW'(1);
            tx_data_q  <= frame_byte(idx_q + IW'(1), shadow_q, csum);
            tx_start_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end else if (wd_tc) begin
          frame_err_q <= 1'b1;
          gap_q       <= GW'(GAP_CYCLES - 1);
          state_q     <= S_GAP;
        end
        S_GAP: if (gap_q == '0) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end else gap_q <= gap_q - 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
endmodule
